// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: stage occupancy encoding
// and the default performance-counter width.
package pipe_pkg;

    typedef logic [1:0] pipe_state_t;

    localparam pipe_state_t ST_EMPTY = 2'b00;
    localparam pipe_state_t ST_ONE   = 2'b01;
    localparam pipe_state_t ST_TWO   = 2'b10;
    // 2'b11 is never entered; the next-state logic folds it back to ST_EMPTY.

    localparam int PIPE_CNT_W = 16;

    function automatic logic state_valid(input pipe_state_t st);
        return (st == ST_ONE) || (st == ST_TWO);
    endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// Width-parametrised up-counter with increment enable that sticks at all-ones.
module pipe_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: valid/ready handshake, 2-entry skid, stall, flush.
// Define PIPE_STAGE_PERF_EN to add the stall/flush saturating performance counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = 64,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
    parameter int                CNT_W      = PIPE_CNT_W
) (
    input  logic              clk_i,
    input  logic              start_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic              flush_i,
    input  logic              stall_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

    if (DATA_W < 1) begin : g_bad_data_w
        $error("pipe_stage_reg: DATA_W must be at least 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("pipe_stage_reg: CNT_W must be at least 1");
    end

    pipe_state_t       st, st_n;
    logic [DATA_W-1:0] main_q, main_n;
    logic [DATA_W-1:0] skid_q, skid_n;
    logic              accept, take;

    // Handshake outputs decode straight from registered state, so ready_o
    // never sees ready_i/stall_i/flush_i combinationally.
    assign valid_o = state_valid(st);
    assign ready_o = (st != ST_TWO);
    assign data_o  = main_q;

    assign accept = valid_i & ready_o;
    assign take   = valid_o & ready_i & ~stall_i;

    always_comb begin
        st_n   = st;
        main_n = main_q;
        skid_n = skid_q;
        case (st)
            ST_EMPTY: begin
                if (accept) begin
                    st_n   = ST_ONE;
                    main_n = data_i;
                end
            end
            ST_ONE: begin
                if (accept && take) begin
                    main_n = data_i;
                end else if (accept) begin
                    st_n   = ST_TWO;
                    skid_n = data_i;
                end else if (take) begin
                    st_n   = ST_EMPTY;
                    main_n = BUBBLE_VAL;
                end
            end
            ST_TWO: begin
                if (take) begin
                    st_n   = ST_ONE;
                    main_n = skid_q;
                    skid_n = BUBBLE_VAL;
                end
            end
            default: begin
                st_n   = ST_EMPTY;
                main_n = BUBBLE_VAL;
                skid_n = BUBBLE_VAL;
            end
        endcase
        // Flush drops every held beat and any beat offered this cycle.
        if (flush_i) begin
            st_n   = ST_EMPTY;
            main_n = BUBBLE_VAL;
            skid_n = BUBBLE_VAL;
        end
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            st     <= ST_EMPTY;
            main_q <= BUBBLE_VAL;
            skid_q <= BUBBLE_VAL;
        end else begin
            st     <= st_n;
            main_q <= main_n;
            skid_q <= skid_n;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    pipe_sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk_i),
        .rst_n (start_i),
        .inc   (valid_o & ~take),
        .cnt   (stall_cnt_o)
    );

    pipe_sat_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk_i),
        .rst_n (start_i),
        .inc   (flush_i),
        .cnt   (flush_cnt_o)
    );
`endif

endmodule
